// File: rtl/valu_writeback_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : valu_writeback_queue                                       |
// | Description : Launches ops into the fixed-latency vector ALU, tracks     |
// |               their tags alongside the ALU stages, captures the scalar   |
// |               or vector result on exit into a small FIFO and hands it    |
// |               to register-file writeback over valid/ready. Issue is      |
// |               credit-gated so the FIFO can never overflow.               |
// | Option      : define VWB_BYPASS_EN to forward an exiting result straight |
// |               to wb_* when the FIFO is empty.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module valu_writeback_queue #(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [4:0]               issue_op,
    input  logic [4:0]               issue_dst,
    input  logic                     issue_is_vec,
    input  logic                     pipe_stall,
    output logic                     alu_en,
    input  logic [31:0]              alu_vout [3:0],
    input  logic [31:0]              alu_rout,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [4:0]               wb_op,
    output logic [4:0]               wb_dst,
    output logic                     wb_is_vec,
    output logic [31:0]              wb_vdata [3:0],
    output logic [31:0]              wb_rdata,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW:0]    c_DEPTH = (CW + 1)'(DEPTH);

    // Tag pipe, index 0 is stage 1, index LATENCY-1 is the exit stage
    logic             r_tvld [LATENCY];
    logic [4:0]       r_top  [LATENCY];
    logic [4:0]       r_tdst [LATENCY];
    logic             r_tvec [LATENCY];

    // Result FIFO storage and bookkeeping
    logic [4:0]       r_mop  [DEPTH];
    logic [4:0]       r_mdst [DEPTH];
    logic             r_mvec [DEPTH];
    logic [31:0]      r_mrd  [DEPTH];
    logic [127:0]     r_mvd  [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_inflight;

    logic             w_accept;
    logic             w_cap;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_valid;
    logic             w_byp_show;
    logic             w_byp_take;
    logic [CW:0]      w_credit_sum;
    logic [31:0]      w_cap_rd;
    logic [127:0]     w_cap_vd;
    logic [127:0]     w_out_vd;

    // Credits use registered counts only, so wb_ready never reaches issue_ready
    assign alu_en       = !pipe_stall && !rst;
    assign w_credit_sum = {1'b0, r_cnt} + {1'b0, r_inflight};
    assign issue_ready  = alu_en && (w_credit_sum < c_DEPTH);
    assign w_accept     = issue_valid && issue_ready;
    assign w_cap        = alu_en && r_tvld[LATENCY-1];
    assign w_fifo_valid = (r_cnt != '0);

`ifdef VWB_BYPASS_EN
    assign w_byp_show   = w_cap && !w_fifo_valid;
`else
    assign w_byp_show   = 1'b0;
`endif
    assign w_byp_take   = w_byp_show && wb_ready;
    assign w_push       = w_cap && !w_byp_take;
    assign w_pop        = w_fifo_valid && wb_ready;

    // Only the field selected by is_vec carries data; the other is stored as zero
    assign w_cap_rd = r_tvec[LATENCY-1] ? 32'h0 : alu_rout;
    assign w_cap_vd = r_tvec[LATENCY-1] ?
                      {alu_vout[3], alu_vout[2], alu_vout[1], alu_vout[0]} : 128'h0;

    // Tag pipe advances only with the ALU so tags stay aligned to its stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_tvld[i] <= 1'b0;
                r_top[i]  <= '0;
                r_tdst[i] <= '0;
                r_tvec[i] <= 1'b0;
            end
        end else if (alu_en) begin
            r_tvld[0] <= w_accept;
            r_top[0]  <= issue_op;
            r_tdst[0] <= issue_dst;
            r_tvec[0] <= issue_is_vec;
            for (int i = 1; i < LATENCY; i++) begin
                r_tvld[i] <= r_tvld[i-1];
                r_top[i]  <= r_top[i-1];
                r_tdst[i] <= r_tdst[i-1];
                r_tvec[i] <= r_tvec[i-1];
            end
        end
    end

    // In-flight count, FIFO occupancy and wrapping pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
            r_cnt      <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
        end else begin
            case ({w_accept, w_cap})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
        end
    end

    // FIFO payload write; contents are qualified by the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mop[r_wp]  <= r_top[LATENCY-1];
            r_mdst[r_wp] <= r_tdst[LATENCY-1];
            r_mvec[r_wp] <= r_tvec[LATENCY-1];
            r_mrd[r_wp]  <= w_cap_rd;
            r_mvd[r_wp]  <= w_cap_vd;
        end
    end

    // Writeback head: FIFO entry first, else a bypassed exiting tag, else zeros
    always_comb begin
        wb_valid  = w_fifo_valid || w_byp_show;
        wb_op     = '0;
        wb_dst    = '0;
        wb_is_vec = 1'b0;
        wb_rdata  = '0;
        w_out_vd  = '0;
        if (w_fifo_valid) begin
            wb_op     = r_mop[r_rp];
            wb_dst    = r_mdst[r_rp];
            wb_is_vec = r_mvec[r_rp];
            wb_rdata  = r_mrd[r_rp];
            w_out_vd  = r_mvd[r_rp];
        end else if (w_byp_show) begin
            wb_op     = r_top[LATENCY-1];
            wb_dst    = r_tdst[LATENCY-1];
            wb_is_vec = r_tvec[LATENCY-1];
            wb_rdata  = w_cap_rd;
            w_out_vd  = w_cap_vd;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_vdata
        assign wb_vdata[g] = w_out_vd[32*g +: 32];
    end

    assign fifo_count = r_cnt;
    assign busy       = (r_inflight != '0) || w_fifo_valid;

endmodule
`default_nettype wire

// File: tb/tb_valu_writeback_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_valu_writeback_queue                                    |
// | Description : Self-checking bench for valu_writeback_queue: vector      |
// |               table, directed corner sequences and random traffic       |
// |               against a queue-based reference model. Honours            |
// |               VWB_BYPASS_EN when defined.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_valu_writeback_queue;

    localparam int LATENCY = 8;
    localparam int DEPTH   = 4;
`ifdef VWB_BYPASS_EN
    localparam int c_EXP_LAT = LATENCY;
    localparam bit c_BYP     = 1'b1;
`else
    localparam int c_EXP_LAT = LATENCY + 1;
    localparam bit c_BYP     = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_op;
    logic [4:0]  issue_dst;
    logic        issue_is_vec;
    logic        pipe_stall;
    logic        alu_en;
    logic [31:0] alu_vout [3:0];
    logic [31:0] alu_rout;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_op;
    logic [4:0]  wb_dst;
    logic        wb_is_vec;
    logic [31:0] wb_vdata [3:0];
    logic [31:0] wb_rdata;
    logic [2:0]  fifo_count;
    logic        busy;

    valu_writeback_queue #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dst(issue_dst), .issue_is_vec(issue_is_vec),
        .pipe_stall(pipe_stall), .alu_en(alu_en),
        .alu_vout(alu_vout), .alu_rout(alu_rout),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_op(wb_op), .wb_dst(wb_dst), .wb_is_vec(wb_is_vec),
        .wb_vdata(wb_vdata), .wb_rdata(wb_rdata),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // An op as the reference sees it: expected writeback fields plus the
    // count of enabled edges at which it was accepted.
    typedef struct {
        logic [4:0]   op;
        logic [4:0]   dst;
        logic         vec;
        logic [31:0]  rd;
        logic [127:0] vd;
        int           acc_n;
    } op_t;

    op_t infl_q[$];
    op_t fifo_q[$];
    int  en_cnt = 0;
    int  n_pass = 0;
    int  n_chk  = 0;

    logic [31:0]  cur_rd;
    logic [127:0] cur_vd;
    logic         last_acc;
    logic         last_wbx;
    logic [4:0]   last_wb_dst;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [127:0] wb_vd();
        return {wb_vdata[3], wb_vdata[2], wb_vdata[1], wb_vdata[0]};
    endfunction

    // Oldest in-flight op has seen LATENCY enabled edges: it sits at the exit
    function automatic bit at_exit();
        if (infl_q.size() == 0) return 1'b0;
        return (infl_q[0].acc_n + LATENCY - 1) == en_cnt;
    endfunction

    // Behavioural ALU: the exiting op's result on the bus, noise otherwise
    task automatic drive_alu();
        alu_rout = $urandom;
        for (int i = 0; i < 4; i++) alu_vout[i] = $urandom;
        if (at_exit()) begin
            if (infl_q[0].vec) begin
                for (int i = 0; i < 4; i++) alu_vout[i] = infl_q[0].vd[32*i +: 32];
            end else begin
                alu_rout = infl_q[0].rd;
            end
        end
    endtask

    task automatic model_reset();
        infl_q.delete();
        fifo_q.delete();
    endtask

    // One clock: check outputs against the model, take the edge, update model
    task automatic tick();
        bit  m_en, m_rdy, cap, byp_show, byp_take, pop, acc, shown;
        op_t e;
        #1;
        m_en     = !pipe_stall && !rst;
        m_rdy    = m_en && ((fifo_q.size() + infl_q.size()) < DEPTH);
        cap      = m_en && at_exit();
        byp_show = c_BYP && cap && (fifo_q.size() == 0);
        shown    = (fifo_q.size() != 0) || byp_show;
        chk("alu_en", alu_en, m_en);
        chk("issue_ready", issue_ready, m_rdy);
        chk("fifo_count", fifo_count, fifo_q.size());
        chk("busy", busy, (infl_q.size() + fifo_q.size()) != 0);
        chk("wb_valid", wb_valid, shown);
        if (shown) begin
            e = (fifo_q.size() != 0) ? fifo_q[0] : infl_q[0];
            chk("wb_op", wb_op, e.op);
            chk("wb_dst", wb_dst, e.dst);
            chk("wb_is_vec", wb_is_vec, e.vec);
            chk("wb_rdata", wb_rdata, e.rd);
            chk("wb_vdata", wb_vd(), e.vd);
        end
        acc         = issue_valid && m_rdy;
        byp_take    = byp_show && wb_ready;
        pop         = (fifo_q.size() != 0) && wb_ready;
        last_acc    = issue_valid && issue_ready;
        last_wbx    = wb_valid && wb_ready;
        last_wb_dst = wb_dst;
        @(posedge clk);
        if (m_en) en_cnt++;
        if (pop) void'(fifo_q.pop_front());
        if (cap) begin
            e = infl_q.pop_front();
            if (!byp_take) fifo_q.push_back(e);
        end
        if (acc) begin
            e.op    = issue_op;
            e.dst   = issue_dst;
            e.vec   = issue_is_vec;
            e.rd    = issue_is_vec ? 32'h0 : cur_rd;
            e.vd    = issue_is_vec ? cur_vd : 128'h0;
            e.acc_n = en_cnt;
            infl_q.push_back(e);
        end
        #1 drive_alu();
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        issue_valid = 1'b0;
        pipe_stall  = 1'b0;
        wb_ready    = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("drain idle", busy, 1'b0);
    endtask

    typedef struct {
        logic         vec;
        logic [4:0]   op;
        logic [4:0]   dst;
        logic [31:0]  rd;
        logic [127:0] vd;
        int           exp_lat;
        logic [31:0]  exp_rd;
        logic [127:0] exp_vd;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int edges, accepts, maxcnt, first_wb;
        logic [4:0] dq[$];

        tbl[0] = '{1'b0, 5'd0,  5'd3,  32'h4040_0000, 128'h0,
                   c_EXP_LAT, 32'h4040_0000, 128'h0};
        tbl[1] = '{1'b1, 5'd2,  5'd7,  32'h0,
                   {32'd1, 32'd2, 32'd3, 32'd4},
                   c_EXP_LAT, 32'h0, {32'd1, 32'd2, 32'd3, 32'd4}};
        tbl[2] = '{1'b0, 5'd31, 5'd31, 32'hFFFF_FFFF, 128'h5555,
                   c_EXP_LAT, 32'hFFFF_FFFF, 128'h0};
        tbl[3] = '{1'b1, 5'd17, 5'd0,  32'h1234_5678,
                   128'hDEAD_BEEF_0000_0001_CAFE_F00D_8000_0000,
                   c_EXP_LAT, 32'h0, 128'hDEAD_BEEF_0000_0001_CAFE_F00D_8000_0000};

        rst          = 1'b1;
        issue_valid  = 1'b0;
        issue_op     = '0;
        issue_dst    = '0;
        issue_is_vec = 1'b0;
        pipe_stall   = 1'b0;
        wb_ready     = 1'b0;
        cur_rd       = '0;
        cur_vd       = '0;
        model_reset();
        drive_alu();
        repeat (2) @(negedge clk);
        #1;
        chk("reset wb_valid", wb_valid, 1'b0);
        chk("reset fifo_count", fifo_count, 3'd0);
        chk("reset busy", busy, 1'b0);
        chk("reset issue_ready", issue_ready, 1'b0);
        chk("reset alu_en", alu_en, 1'b0);
        chk("reset wb_fields", {wb_op, wb_dst, wb_is_vec, wb_rdata}, '0);
        chk("reset wb_vdata", wb_vd(), 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: single ops through an idle queue
        for (int k = 0; k < 4; k++) begin
            wb_ready     = 1'b1;
            issue_valid  = 1'b1;
            issue_op     = tbl[k].op;
            issue_dst    = tbl[k].dst;
            issue_is_vec = tbl[k].vec;
            cur_rd       = tbl[k].rd;
            cur_vd       = tbl[k].vd;
            tick();
            chk("tbl accept", last_acc, 1'b1);
            issue_valid = 1'b0;
            edges = 1;
            while (!wb_valid && edges < 40) begin
                tick();
                edges++;
            end
            chk("tbl latency", edges, tbl[k].exp_lat);
            chk("tbl wb_dst", wb_dst, tbl[k].dst);
            chk("tbl wb_op", wb_op, tbl[k].op);
            chk("tbl wb_rdata", wb_rdata, tbl[k].exp_rd);
            chk("tbl wb_vdata", wb_vd(), tbl[k].exp_vd);
            chk("tbl fifo_count", fifo_count, c_BYP ? 3'd0 : 3'd1);
            repeat (3) tick();
            chk("tbl drained", fifo_count, 3'd0);
        end

        // Back-pressure: credits stop issue at DEPTH
        wb_ready     = 1'b0;
        issue_valid  = 1'b1;
        issue_is_vec = 1'b0;
        accepts      = 0;
        for (int i = 0; i < 20; i++) begin
            issue_dst = 5'(i);
            cur_rd    = $urandom;
            tick();
            if (last_acc) accepts++;
        end
        chk("bp accepts", accepts, DEPTH);
        chk("bp fifo_count", fifo_count, 3'd4);
        chk("bp wb_valid", wb_valid, 1'b1);
        chk("bp issue_ready", issue_ready, 1'b0);
        issue_valid = 1'b0;
        wb_ready    = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("bp after pop", fifo_count, 3'd3);
        issue_valid = 1'b1;
        accepts     = 0;
        repeat (6) begin
            tick();
            if (last_acc) accepts++;
        end
        chk("bp one credit", accepts, 1);
        drain();

        // Stall at stage 4 for five cycles
        wb_ready     = 1'b0;
        issue_valid  = 1'b1;
        issue_is_vec = 1'b1;
        issue_dst    = 5'd7;
        issue_op     = 5'd9;
        cur_vd       = {32'd1, 32'd2, 32'd3, 32'd4};
        tick();
        issue_valid = 1'b0;
        edges = 1;
        repeat (3) begin
            tick();
            edges++;
        end
        pipe_stall = 1'b1;
        repeat (5) begin
            tick();
            edges++;
        end
        chk("stall alu_en", alu_en, 1'b0);
        chk("stall no capture", wb_valid, 1'b0);
        pipe_stall = 1'b0;
        while (!wb_valid && edges < 60) begin
            tick();
            edges++;
        end
        chk("stall latency", edges, c_EXP_LAT + 5);
        chk("stall wb_vdata", wb_vd(), {32'd1, 32'd2, 32'd3, 32'd4});
        chk("stall wb_dst", wb_dst, 5'd7);
        chk("stall wb_is_vec", wb_is_vec, 1'b1);
        tick();
        chk("stall enqueued", fifo_count, 3'd1);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        tick();
        chk("stall single capture", fifo_count, 3'd0);
        chk("stall wb_valid low", wb_valid, 1'b0);
        drain();

        // Stream with wb_ready high: order preserved, FIFO never backs up
        wb_ready     = 1'b1;
        issue_is_vec = 1'b0;
        maxcnt       = 0;
        first_wb     = -1;
        dq.delete();
        for (int i = 0; i < 60; i++) begin
            issue_valid = (dq.size() + infl_q.size() + fifo_q.size()) < 10 && issue_dst < 5'd10;
            if (i == 0) begin
                issue_dst   = 5'd0;
                issue_valid = 1'b1;
            end
            cur_rd = $urandom;
            tick();
            if (last_acc) issue_dst = issue_dst + 5'd1;
            if (last_wbx) dq.push_back(last_wb_dst);
            if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
        end
        issue_valid = 1'b0;
        chk("stream count", dq.size(), 10);
        for (int i = 0; i < 10 && i < dq.size(); i++) chk("stream order", dq[i], 5'(i));
        chk("stream max fifo", maxcnt, c_BYP ? 0 : 1);
        drain();

        // Reset with three ops in flight
        wb_ready    = 1'b1;
        issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue_dst = 5'(20 + i);
            tick();
        end
        issue_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst wb_valid", wb_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst issue_ready", issue_ready, 1'b0);
        chk("rst alu_en", alu_en, 1'b0);
        tick();
        rst          = 1'b0;
        issue_valid  = 1'b1;
        issue_dst    = 5'd9;
        issue_is_vec = 1'b0;
        cur_rd       = 32'hA5A5_0009;
        tick();
        chk("rst first accept", last_acc, 1'b1);
        issue_valid = 1'b0;
        dq.delete();
        repeat (30) begin
            tick();
            if (last_wbx) dq.push_back(last_wb_dst);
        end
        chk("rst wb count", dq.size(), 1);
        if (dq.size() > 0) chk("rst wb dst", dq[0], 5'd9);

        // Random traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            issue_valid  = 1'($urandom_range(0, 1));
            issue_op     = 5'($urandom);
            issue_dst    = 5'($urandom);
            issue_is_vec = 1'($urandom);
            pipe_stall   = ($urandom_range(0, 4) == 0);
            wb_ready     = ($urandom_range(0, 2) != 0);
            cur_rd       = $urandom;
            cur_vd       = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
